// File: rtl/ram_ctrl_pkg.sv
// Shared opcodes, widths and FSM encoding for the command-RAM access controller.
package ram_ctrl_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_CMD  = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  function automatic logic [CMD_W-1:0] cmd_word(input logic [1:0] op,
                                                input logic [DATA_W-1:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/ram_rr_arb2.sv
// Two-way round-robin arbiter; 'last' remembers the most recent winner.
module ram_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

  // Reset to 1 so requester 0 wins the first contested grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last <= 1'b1;
    else if (update && (grant != 2'b00)) last <= grant[1];
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Shares the single-port command RAM between two requesters and expands each
// transaction into the RAM opcode sequence.
//
// state    | meaning
// IDLE     | sample req, grant and latch the winner's command
// WR_ADDR  | drive write-address word
// WR_DATA  | drive write-data word
// RD_ADDR  | drive read-address word
// RD_CMD   | drive read-data request word
// RD_WAIT  | wait for ram_tx_valid, bounded by TIMEOUT
// DONE     | done pulse to owner, gnt released on exit
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req,
  input  logic [1:0]             we,
  input  logic [2*ADDR_SIZE-1:0] addr,
  input  logic [15:0]            wdata,
  output logic [1:0]             gnt,
  output logic [1:0]             done,
  output logic [DATA_W-1:0]      rdata,
  output logic                   err,
  output logic [CMD_W-1:0]       ram_din,
  output logic                   ram_rx_valid,
  input  logic [DATA_W-1:0]      ram_dout,
  input  logic                   ram_tx_valid
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t                 state, state_nxt;
  logic [1:0]             arb_gnt, gnt_nxt, done_nxt;
  logic [DATA_W-1:0]      rdata_nxt, op_wdata, sel_wdata;
  logic                   err_nxt, op_we, sel_we, latch_en, ram_rx_valid_nxt;
  logic [CMD_W-1:0]       ram_din_nxt;
  logic [ADDR_SIZE-1:0]   op_addr, sel_addr;
  logic [CNT_W-1:0]       cnt, cnt_nxt;

  function automatic logic [DATA_W-1:0] pad_addr(input logic [ADDR_SIZE-1:0] a);
    logic [DATA_W-1:0] p;
    p = '0;
    p[ADDR_SIZE-1:0] = a;
    return p;
  endfunction

  ram_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update ((state == ST_IDLE) && (|req)),
    .grant  (arb_gnt)
  );

  assign sel_we    = arb_gnt[1] ? we[1] : we[0];
  assign sel_addr  = arb_gnt[1] ? addr[2*ADDR_SIZE-1:ADDR_SIZE] : addr[ADDR_SIZE-1:0];
  assign sel_wdata = arb_gnt[1] ? wdata[15:8] : wdata[7:0];

  // Outputs are computed for the state being entered, so they are registered
  // yet line up with the state they belong to.
  always_comb begin
    state_nxt        = state;
    gnt_nxt          = gnt;
    done_nxt         = 2'b00;
    rdata_nxt        = rdata;
    err_nxt          = err;
    ram_din_nxt      = '0;
    ram_rx_valid_nxt = 1'b0;
    cnt_nxt          = cnt;
    latch_en         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|req) begin
          latch_en         = 1'b1;
          gnt_nxt          = arb_gnt;
          ram_rx_valid_nxt = 1'b1;
          if (sel_we) begin
            state_nxt   = ST_WR_ADDR;
            ram_din_nxt = cmd_word(OP_WR_ADDR, pad_addr(sel_addr));
          end else begin
            state_nxt   = ST_RD_ADDR;
            ram_din_nxt = cmd_word(OP_RD_ADDR, pad_addr(sel_addr));
          end
        end
      end
      ST_WR_ADDR: begin
        state_nxt        = ST_WR_DATA;
        ram_rx_valid_nxt = 1'b1;
        ram_din_nxt      = cmd_word(OP_WR_DATA, op_wdata);
      end
      ST_WR_DATA: begin
        state_nxt = ST_DONE;
        done_nxt  = gnt;
        err_nxt   = 1'b0;
      end
      ST_RD_ADDR: begin
        state_nxt        = ST_RD_CMD;
        ram_rx_valid_nxt = 1'b1;
        ram_din_nxt      = cmd_word(OP_RD_DATA, 8'h00);
      end
      ST_RD_CMD: begin
        state_nxt = ST_RD_WAIT;
        cnt_nxt   = CNT_W'(TIMEOUT);
      end
      ST_RD_WAIT: begin
        // Data arriving on the terminal count still wins over the timeout.
        if (ram_tx_valid) begin
          state_nxt = ST_DONE;
          done_nxt  = gnt;
          rdata_nxt = ram_dout;
          err_nxt   = 1'b0;
        end else if (cnt == '0) begin
          state_nxt = ST_DONE;
          done_nxt  = gnt;
          rdata_nxt = '0;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = 2'b00;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      gnt          <= 2'b00;
      done         <= 2'b00;
      rdata        <= '0;
      err          <= 1'b0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      cnt          <= '0;
      op_we        <= 1'b0;
      op_addr      <= '0;
      op_wdata     <= '0;
    end else begin
      state        <= state_nxt;
      gnt          <= gnt_nxt;
      done         <= done_nxt;
      rdata        <= rdata_nxt;
      err          <= err_nxt;
      ram_din      <= ram_din_nxt;
      ram_rx_valid <= ram_rx_valid_nxt;
      cnt          <= cnt_nxt;
      if (latch_en) begin
        op_we    <= sel_we;
        op_addr  <= sel_addr;
        op_wdata <= sel_wdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed and randomized checks of ram_access_ctrl paired with a small RAM model.
module tb_ram_access_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [15:0] addr, wdata;
  logic [1:0]  gnt, done;
  logic [7:0]  rdata;
  logic        err;
  logic [9:0]  ram_din;
  logic        ram_rx_valid;
  logic [7:0]  ram_dout;
  logic        ram_tx_valid;

  int total = 0;
  int bad   = 0;

  logic [7:0] ram_mem [8];
  logic [7:0] ref_mem [8];
  logic [2:0] ram_ptr;
  int         ref_last;
  logic [7:0] ref_rdata;

  ram_access_ctrl #(.ADDR_SIZE(8), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .gnt          (gnt),
    .done         (done),
    .rdata        (rdata),
    .err          (err),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RAM side: consumes the command word presented during the current cycle.
  task automatic ram_step(output bit rd_cmd);
    rd_cmd = 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00, 2'b10: ram_ptr = ram_din[2:0];
        2'b01:        ram_mem[ram_ptr] = ram_din[7:0];
        default:      rd_cmd = 1'b1;
      endcase
    end
  endtask

  // One isolated transaction; lat < 0 means the RAM never answers the read.
  task automatic txn(input int i, input bit w, input logic [7:0] a,
                     input logic [7:0] d, input int lat);
    logic [9:0] cmds[$];
    logic [9:0] exp_cmds[$];
    logic [1:0] oh;
    logic [7:0] exp_rd;
    logic       exp_err;
    int         done_at, exp_done, rd_cmd_at;
    bit         rdc;
    oh = (i == 0) ? 2'b01 : 2'b10;
    exp_rd = 8'h00;
    exp_err = 1'b0;
    req[i] = 1'b1;
    we[i] = w;
    addr[i*8 +: 8] = a;
    wdata[i*8 +: 8] = d;
    if (w) begin
      exp_cmds.push_back({2'b00, a});
      exp_cmds.push_back({2'b01, d});
      exp_done = 3;
      ref_mem[a[2:0]] = d;
    end else begin
      exp_cmds.push_back({2'b10, a});
      exp_cmds.push_back({2'b11, 8'h00});
      if (lat >= 0 && lat <= TIMEOUT) begin
        exp_done = 4 + lat;
        exp_rd = ref_mem[a[2:0]];
        exp_err = 1'b0;
      end else begin
        exp_done = 4 + TIMEOUT;
        exp_rd = 8'h00;
        exp_err = 1'b1;
      end
      ref_rdata = exp_rd;
    end
    done_at = -1;
    rd_cmd_at = -1;
    for (int n = 1; n <= 40 && done_at < 0; n++) begin
      tick();
      ram_tx_valid = 1'b0;
      ram_dout = 8'($urandom);
      chk("gnt_owner", gnt, oh);
      if (ram_rx_valid) cmds.push_back(ram_din);
      ram_step(rdc);
      if (rdc) rd_cmd_at = n;
      if (done !== 2'b00) begin
        done_at = n;
        chk("done_owner", done, oh);
        if (!w) begin
          chk("rdata", rdata, exp_rd);
          chk("err", err, exp_err);
        end
        req[i] = 1'b0;
      end else if (rd_cmd_at > 0 && lat >= 0 && n == rd_cmd_at + 1 + lat) begin
        ram_tx_valid = 1'b1;
        ram_dout = ram_mem[ram_ptr];
      end
    end
    ram_tx_valid = 1'b0;
    req[i] = 1'b0;
    chk("done_latency", done_at, exp_done);
    chk("cmd_count", cmds.size(), exp_cmds.size());
    for (int k = 0; k < cmds.size() && k < exp_cmds.size(); k++)
      chk("cmd_word", cmds[k], exp_cmds[k]);
    if (w) chk("mem_write", ram_mem[a[2:0]], d);
    tick();
    chk("gnt_release", gnt, 2'b00);
    chk("done_single", done, 2'b00);
    ref_last = i;
  endtask

  // Both requesters keep writing; each re-raises req one cycle after its done.
  task automatic both(input int count);
    int   order[$];
    int   exp_first;
    int   rearm;
    bit   rdc;
    logic [7:0] a0, d0, d1;
    a0 = 8'($urandom);
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    we = 2'b11;
    addr = {a0 ^ 8'h01, a0};
    wdata = {d1, d0};
    exp_first = (ref_last == 1) ? 0 : 1;
    req = 2'b11;
    rearm = -1;
    for (int cyc = 0; cyc < count * 8 && order.size() < count; cyc++) begin
      tick();
      ram_step(rdc);
      chk("gnt_exclusive", $countones(gnt) <= 1, 1);
      if (rearm >= 0) begin
        req[rearm] = 1'b1;
        rearm = -1;
      end
      if (done !== 2'b00) begin
        chk("done_exclusive", $countones(done), 1);
        order.push_back(done[1] ? 1 : 0);
        req[done[1] ? 1 : 0] = 1'b0;
        rearm = done[1] ? 1 : 0;
      end
    end
    req = 2'b00;
    chk("rr_count", order.size(), count);
    for (int k = 0; k < order.size(); k++)
      chk("rr_order", order[k], (exp_first + k) % 2);
    ref_mem[a0[2:0]] = d0;
    ref_mem[a0[2:0] ^ 3'd1] = d1;
    ref_last = (exp_first + count - 1) % 2;
    tick();
    chk("rr_idle_gnt", gnt, 2'b00);
    chk("rr_mem0", ram_mem[a0[2:0]], d0);
    chk("rr_mem1", ram_mem[a0[2:0] ^ 3'd1], d1);
  endtask

  initial begin
    int   ri, rw, rr, rlat;
    bit   rdc;
    rst = 1'b1;
    req = 2'b00;
    we = 2'b00;
    addr = '0;
    wdata = '0;
    ram_dout = 8'h00;
    ram_tx_valid = 1'b0;
    ram_ptr = 3'd0;
    for (int k = 0; k < 8; k++) begin
      ram_mem[k] = 8'h00;
      ref_mem[k] = 8'h00;
    end
    ref_last = 1;
    ref_rdata = 8'h00;

    tick();
    tick();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_err", err, 1'b0);
    chk("rst_din", ram_din, 10'h000);
    chk("rst_rxv", ram_rx_valid, 1'b0);
    rst = 1'b0;
    tick();

    txn(0, 1'b1, 8'h02, 8'h6A, 0);
    txn(1, 1'b0, 8'h02, 8'h00, 2);

    // ram_tx_valid outside RD_WAIT must be ignored
    ram_tx_valid = 1'b1;
    ram_dout = 8'h55;
    tick();
    ram_tx_valid = 1'b0;
    tick();
    chk("idle_txv_rdata", rdata, ref_rdata);
    chk("idle_txv_done", done, 2'b00);
    chk("idle_txv_gnt", gnt, 2'b00);
    chk("idle_txv_rxv", ram_rx_valid, 1'b0);

    txn(0, 1'b0, 8'h05, 8'h00, -1);
    txn(1, 1'b0, 8'h02, 8'h00, TIMEOUT);
    txn(0, 1'b0, 8'h02, 8'h00, TIMEOUT + 1);

    // Reset during WR_DATA aborts silently
    req[1] = 1'b1;
    we[1] = 1'b1;
    addr[15:8] = 8'h03;
    wdata[15:8] = 8'hC3;
    tick();
    chk("abort_gnt", gnt, 2'b10);
    tick();
    chk("abort_wrdata", ram_din, 10'h1C3);
    rst = 1'b1;
    #1;
    chk("abort_gnt0", gnt, 2'b00);
    chk("abort_done0", done, 2'b00);
    chk("abort_rdata0", rdata, 8'h00);
    chk("abort_err0", err, 1'b0);
    chk("abort_din0", ram_din, 10'h000);
    chk("abort_rxv0", ram_rx_valid, 1'b0);
    req = 2'b00;
    tick();
    ram_step(rdc);
    chk("abort_no_done", done, 2'b00);
    chk("abort_no_write", ram_mem[3], ref_mem[3]);
    rst = 1'b0;
    ref_last = 1;
    ref_rdata = 8'h00;
    tick();

    both(4);

    for (int t = 0; t < 24; t++) begin
      ri = $urandom_range(0, 1);
      rw = $urandom_range(0, 1);
      rr = $urandom_range(0, 9);
      rlat = (rr == 0) ? -1 : $urandom_range(0, TIMEOUT + 2);
      txn(ri, rw[0], 8'($urandom), 8'($urandom), rlat);
    end

    both(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
